// File: rtl/ifetch_ctrl_if.sv
// Instruction-memory read bus between the fetch controller (master) and memory (slave).
// Single outstanding request; Mem_Req is a level held until the Mem_Rvalid pulse.
interface ifetch_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              Mem_Req;
   logic [ADDR_W-1:0] Mem_Addr;
   logic [DATA_W-1:0] Mem_Rdata;
   logic              Mem_Rvalid;

   modport master (
      output Mem_Req,
      output Mem_Addr,
      input  Mem_Rdata,
      input  Mem_Rvalid
   );

   modport slave (
      input  Mem_Req,
      input  Mem_Addr,
      output Mem_Rdata,
      output Mem_Rvalid
   );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: one outstanding memory read per PC, holds the word for
// decode, drives PC_LdEn, and handles stall, flush and fetch timeout.
module ifetch_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [ADDR_W-1:0] Curr_Addr,
   input  logic              Ifu_Stall,
   input  logic              Flush,
   ifetch_ctrl_if.master     mem,
   output logic [DATA_W-1:0] Instr,
   output logic [ADDR_W-1:0] Instr_PC,
   output logic              Instr_Valid,
   output logic              PC_LdEn,
   output logic              Fetch_Err
);

   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WAIT = 3'd1;
   localparam logic [2:0] S_HOLD = 3'd2;
   localparam logic [2:0] S_DROP = 3'd3;
   localparam logic [2:0] S_ERR  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] ipc_q, ipc_d;
   logic              vld_q, vld_d;
   logic              err_q, err_d;

   logic [TW-1:0]     timer_inc;
   logic              timeout_hit;

   // Timer counts cycles spent waiting; the cycle it would reach TIMEOUT is the last one allowed.
   assign timer_inc   = (timer_q == TW'(TIMEOUT)) ? timer_q : timer_q + 1'b1;
   assign timeout_hit = (timer_q >= TW'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      req_d   = req_q;
      addr_d  = addr_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      vld_d   = vld_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (Curr_Addr[1:0] != 2'b00) begin
               state_d = S_ERR;
               err_d   = 1'b1;
            end else begin
               state_d = S_WAIT;
               addr_d  = Curr_Addr;
               req_d   = 1'b1;
               timer_d = '0;
            end
         end
         S_WAIT: begin
            if (mem.Mem_Rvalid) begin
               req_d = 1'b0;
               if (!Flush) begin
                  state_d = S_HOLD;
                  instr_d = mem.Mem_Rdata;
                  ipc_d   = addr_q;
                  vld_d   = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end else if (timeout_hit) begin
               state_d = S_ERR;
               req_d   = 1'b0;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_inc;
               // The bus has no abort, so a flushed request must still be drained.
               if (Flush) state_d = S_DROP;
            end
         end
         S_DROP: begin
            if (mem.Mem_Rvalid) begin
               state_d = S_IDLE;
               req_d   = 1'b0;
            end else if (timeout_hit) begin
               state_d = S_ERR;
               req_d   = 1'b0;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_inc;
            end
         end
         S_HOLD: begin
            if (!Ifu_Stall || Flush) begin
               state_d = S_IDLE;
               vld_d   = 1'b0;
            end
         end
         S_ERR: begin
            req_d = 1'b0;
            vld_d = 1'b0;
            err_d = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            vld_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         req_q   <= 1'b0;
         addr_q  <= '0;
         instr_q <= '0;
         ipc_q   <= '0;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
         vld_q   <= vld_d;
         err_q   <= err_d;
      end
   end

   // Upstream next-PC mux picks the redirect target whenever Flush is high.
   assign PC_LdEn = ((state_q == S_HOLD) && !Ifu_Stall) || (Flush && (state_q != S_ERR));

   assign mem.Mem_Req  = req_q;
   assign mem.Mem_Addr = addr_q;
   assign Instr        = instr_q;
   assign Instr_PC     = ipc_q;
   assign Instr_Valid  = vld_q;
   assign Fetch_Err    = err_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed vector table, hand-written corner sequences, and
// randomized traffic compared against a transaction-level reference model.
module tb_ifetch_ctrl;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 15;

   logic          Clk = 1'b0;
   logic          Reset = 1'b0;
   logic [AW-1:0] Curr_Addr = '0;
   logic          Ifu_Stall = 1'b0;
   logic          Flush = 1'b0;
   logic [DW-1:0] Instr;
   logic [AW-1:0] Instr_PC;
   logic          Instr_Valid;
   logic          PC_LdEn;
   logic          Fetch_Err;

   ifetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

   ifetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Curr_Addr   (Curr_Addr),
      .Ifu_Stall   (Ifu_Stall),
      .Flush       (Flush),
      .mem         (mem_if.master),
      .Instr       (Instr),
      .Instr_PC    (Instr_PC),
      .Instr_Valid (Instr_Valid),
      .PC_LdEn     (PC_LdEn),
      .Fetch_Err   (Fetch_Err)
   );

   always #5 Clk = ~Clk;

   int errors = 0;
   int checks = 0;

   // Reference model: tracks what a fetch unit must be doing, not how the RTL encodes it.
   logic          m_dead, m_outstanding, m_discard, m_holding;
   logic [AW-1:0] m_addr, m_ipc;
   logic [DW-1:0] m_instr;
   int            m_waited;

   typedef struct {
      logic [31:0] curr;
      logic        stall, flush, rvalid;
      logic [31:0] rdata;
      logic        req;
      logic [31:0] addr;
      logic        ivld;
      logic [31:0] instr, ipc;
      logic        ld, err;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mk(logic [31:0] curr, logic st, logic fl, logic rv, logic [31:0] rd,
                               logic req, logic [31:0] addr, logic ivld, logic [31:0] instr,
                               logic [31:0] ipc, logic ld, logic err);
      vec_t v;
      v.curr = curr; v.stall = st; v.flush = fl; v.rvalid = rv; v.rdata = rd;
      v.req = req; v.addr = addr; v.ivld = ivld; v.instr = instr; v.ipc = ipc;
      v.ld = ld; v.err = err;
      return v;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] dut_outs();
      return {28'd0, mem_if.Mem_Req, mem_if.Mem_Addr, Instr_Valid, Instr, Instr_PC, PC_LdEn, Fetch_Err};
   endfunction

   function automatic logic [127:0] model_outs(input logic stall, input logic flush);
      logic ld;
      ld = !m_dead && (flush || (m_holding && !stall));
      return {28'd0, m_outstanding, m_addr, m_holding, m_instr, m_ipc, ld, m_dead};
   endfunction

   task automatic model_reset();
      m_dead = 0; m_outstanding = 0; m_discard = 0; m_holding = 0;
      m_addr = '0; m_ipc = '0; m_instr = '0; m_waited = 0;
   endtask

   task automatic model_update(input logic [AW-1:0] curr, input logic stall, input logic flush,
                               input logic rvalid, input logic [DW-1:0] rdata);
      if (m_dead) begin
      end else if (m_outstanding) begin
         if (rvalid) begin
            m_outstanding = 0;
            if (!m_discard && !flush) begin
               m_holding = 1; m_instr = rdata; m_ipc = m_addr;
            end
            m_discard = 0;
         end else if (m_waited + 1 >= TO) begin
            m_dead = 1; m_outstanding = 0; m_discard = 0;
         end else begin
            m_waited++;
            if (flush) m_discard = 1;
         end
      end else if (m_holding) begin
         if (!stall || flush) m_holding = 0;
      end else if (curr[1:0] != 2'b00) begin
         m_dead = 1;
      end else begin
         m_outstanding = 1; m_addr = curr; m_waited = 0;
      end
   endtask

   task automatic drive(input logic [AW-1:0] curr, input logic st, input logic fl,
                        input logic rv, input logic [DW-1:0] rd);
      Curr_Addr = curr; Ifu_Stall = st; Flush = fl;
      mem_if.Mem_Rvalid = rv; mem_if.Mem_Rdata = rd;
   endtask

   task automatic step(input string name, input logic [AW-1:0] curr, input logic st,
                       input logic fl, input logic rv, input logic [DW-1:0] rd);
      @(negedge Clk);
      drive(curr, st, fl, rv, rd);
      #1;
      check(name, dut_outs(), model_outs(st, fl));
      @(posedge Clk);
      model_update(curr, st, fl, rv, rd);
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset = 1'b0;
      drive('0, 1'b0, 1'b0, 1'b0, '0);
      #1;
      check("reset_state", dut_outs(), 128'd0);
      @(posedge Clk);
      #1;
      Reset = 1'b1;
      model_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rv_pct;
      logic [AW-1:0] c;
      mem_if.Mem_Rvalid = 1'b0;
      mem_if.Mem_Rdata  = '0;

      // Directed sequence: basic fetch, stalled hold, flush in wait, flush with rvalid.
      tbl[0]  = mk(32'h00, 0, 0, 0, 32'h0,         0, 32'h00, 0, 32'h0,         32'h00, 0, 0);
      tbl[1]  = mk(32'h00, 0, 0, 0, 32'h0,         1, 32'h00, 0, 32'h0,         32'h00, 0, 0);
      tbl[2]  = mk(32'h00, 0, 0, 0, 32'h0,         1, 32'h00, 0, 32'h0,         32'h00, 0, 0);
      tbl[3]  = mk(32'h00, 0, 0, 1, 32'h20020005,  1, 32'h00, 0, 32'h0,         32'h00, 0, 0);
      tbl[4]  = mk(32'h00, 0, 0, 0, 32'h0,         0, 32'h00, 1, 32'h20020005,  32'h00, 1, 0);
      tbl[5]  = mk(32'h04, 0, 0, 0, 32'h0,         0, 32'h00, 0, 32'h20020005,  32'h00, 0, 0);
      tbl[6]  = mk(32'h04, 0, 0, 1, 32'h11110001,  1, 32'h04, 0, 32'h20020005,  32'h00, 0, 0);
      tbl[7]  = mk(32'h04, 1, 0, 0, 32'h0,         0, 32'h04, 1, 32'h11110001,  32'h04, 0, 0);
      tbl[8]  = mk(32'h04, 1, 0, 0, 32'h0,         0, 32'h04, 1, 32'h11110001,  32'h04, 0, 0);
      tbl[9]  = mk(32'h04, 1, 0, 0, 32'h0,         0, 32'h04, 1, 32'h11110001,  32'h04, 0, 0);
      tbl[10] = mk(32'h04, 0, 0, 0, 32'h0,         0, 32'h04, 1, 32'h11110001,  32'h04, 1, 0);
      tbl[11] = mk(32'h10, 0, 0, 0, 32'h0,         0, 32'h04, 0, 32'h11110001,  32'h04, 0, 0);
      tbl[12] = mk(32'h10, 0, 1, 0, 32'h0,         1, 32'h10, 0, 32'h11110001,  32'h04, 1, 0);
      tbl[13] = mk(32'h40, 0, 0, 0, 32'h0,         1, 32'h10, 0, 32'h11110001,  32'h04, 0, 0);
      tbl[14] = mk(32'h40, 0, 0, 1, 32'hDEADBEEF,  1, 32'h10, 0, 32'h11110001,  32'h04, 0, 0);
      tbl[15] = mk(32'h40, 0, 0, 0, 32'h0,         0, 32'h10, 0, 32'h11110001,  32'h04, 0, 0);
      tbl[16] = mk(32'h40, 0, 1, 1, 32'hBAD00000,  1, 32'h40, 0, 32'h11110001,  32'h04, 1, 0);
      tbl[17] = mk(32'h80, 0, 0, 0, 32'h0,         0, 32'h40, 0, 32'h11110001,  32'h04, 0, 0);
      tbl[18] = mk(32'h80, 0, 0, 1, 32'h12345678,  1, 32'h80, 0, 32'h11110001,  32'h04, 0, 0);
      tbl[19] = mk(32'h84, 0, 0, 0, 32'h0,         0, 32'h80, 1, 32'h12345678,  32'h80, 1, 0);

      do_reset();
      for (int i = 0; i < 20; i++) begin
         @(negedge Clk);
         drive(tbl[i].curr, tbl[i].stall, tbl[i].flush, tbl[i].rvalid, tbl[i].rdata);
         #1;
         check($sformatf("vec%0d", i), dut_outs(),
               {28'd0, tbl[i].req, tbl[i].addr, tbl[i].ivld, tbl[i].instr, tbl[i].ipc, tbl[i].ld, tbl[i].err});
         @(posedge Clk);
      end

      // Timeout: error only on the TIMEOUT-th cycle without read data, then sticky.
      do_reset();
      step("to_idle", 32'h0, 0, 0, 0, '0);
      for (int i = 0; i < TO - 1; i++) step("to_wait", 32'h0, 0, 0, 0, '0);
      #1;
      check("to_before_limit", {126'd0, Fetch_Err, mem_if.Mem_Req}, 128'b01);
      step("to_last", 32'h0, 0, 0, 0, '0);
      #1;
      check("to_at_limit", {126'd0, Fetch_Err, mem_if.Mem_Req}, 128'b10);
      step("to_late_rvalid", 32'h0, 0, 0, 1, 32'hCAFE0000);
      step("to_late_flush", 32'h8, 0, 1, 0, '0);
      @(negedge Clk);
      drive(32'h0, 1'b0, 1'b1, 1'b1, 32'h1);
      #1;
      check("err_ldEn_flush", {127'd0, PC_LdEn}, 128'd0);
      check("err_ivld", {127'd0, Instr_Valid}, 128'd0);

      // Misaligned PC goes straight to error without a request.
      do_reset();
      step("mis_idle", 32'h6, 0, 0, 0, '0);
      #1;
      check("mis_err", {126'd0, Fetch_Err, mem_if.Mem_Req}, 128'b10);
      step("mis_stay", 32'h8, 0, 0, 0, '0);

      // Asynchronous reset between clock edges while waiting on memory.
      do_reset();
      step("ar_idle", 32'h20, 0, 0, 0, '0);
      step("ar_wait", 32'h20, 0, 0, 0, '0);
      @(negedge Clk);
      drive(32'h20, 1'b0, 1'b0, 1'b0, '0);
      #2;
      Reset = 1'b0;
      #1;
      check("async_reset", dut_outs(), 128'd0);
      @(posedge Clk);
      #1;
      Reset = 1'b1;
      model_reset();
      step("ar_restart_idle", 32'h100, 0, 0, 0, '0);
      step("ar_restart_wait", 32'h100, 0, 0, 1, 32'h0BADF00D);
      step("ar_restart_hold", 32'h100, 0, 0, 0, '0);

      // Randomized traffic with varying memory responsiveness.
      do_reset();
      rv_pct = 40;
      for (int i = 0; i < 3000; i++) begin
         if (i % 500 == 0) rv_pct = (i / 500 == 1) ? 10 : (i / 500 == 2) ? 70 :
                                    (i / 500 == 3) ? 20 : (i / 500 == 4) ? 55 : 40;
         if (m_dead && $urandom_range(0, 3) == 0) do_reset();
         c = $urandom;
         if ($urandom_range(0, 199) != 0) c[1:0] = 2'b00;
         step("rand", c, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
              $urandom_range(0, 99) < rv_pct, $urandom);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
